// File: rtl/sram_responder.sv
// Cycle-based responder for a 256K x 16 asynchronous SRAM: programmable read latency,
// byte-lane masking, tri-state data bus, protocol-violation flag and transaction counters.
module sram_responder #(
    parameter int DEPTH_LOG2 = 16,
    parameter int READ_LAT   = 2,
    parameter int WR_MIN     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] sramAddress,
    inout  wire  [15:0] sramData,
    input  logic [4:0]  sramCtrl,
    output logic [15:0] readCount,
    output logic [15:0] writeCount,
    output logic        protocolErr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAIT    = 2'd1,
        READ_DRIVE   = 2'd2,
        WRITE_ACTIVE = 2'd3
    } state_t;

    localparam logic [4:0] LAT  = 5'(READ_LAT);
    localparam logic [3:0] WMIN = 4'(WR_MIN);
    localparam int         WORDS = 2 ** DEPTH_LOG2;

    state_t                  state;
    logic [15:0]             mem [WORDS];
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic [DEPTH_LOG2-1:0]   w_addr;
    logic [15:0]             w_data;
    logic                    w_ub_n;
    logic                    w_lb_n;
    logic [3:0]              cnt;
    logic [4:0]              cnt_inc;
    logic [3:0]              wcnt;
    logic [15:0]             rdata;

    logic we_n;
    logic oe_n;
    logic ub_n;
    logic lb_n;
    logic ce_n;
    logic rd;
    logic wr;
    logic both_low;
    logic commit;
    logic drive_hi;
    logic drive_lo;
    logic unused_addr;

    // Address bits above the implemented depth are ignored, so accesses alias.
    assign idx         = sramAddress[DEPTH_LOG2-1:0];
    assign unused_addr = ^sramAddress;

    assign we_n = sramCtrl[4];
    assign oe_n = sramCtrl[3];
    assign ub_n = sramCtrl[2];
    assign lb_n = sramCtrl[1];
    assign ce_n = sramCtrl[0];

    assign rd       = !ce_n && we_n && !oe_n;
    assign wr       = !ce_n && !we_n;
    assign both_low = !ce_n && !we_n && !oe_n;

    assign cnt_inc = {1'b0, cnt} + 5'd1;
    assign commit  = (state == WRITE_ACTIVE) && !wr && (wcnt >= WMIN);

    // Bus drive is combinational so the lanes release the moment the controller deasserts.
    assign drive_hi = (state == READ_DRIVE) && rd && (idx == r_addr) && !ub_n;
    assign drive_lo = (state == READ_DRIVE) && rd && (idx == r_addr) && !lb_n;

    assign sramData[15:8] = drive_hi ? rdata[15:8] : 8'bzzzz_zzzz;
    assign sramData[7:0]  = drive_lo ? rdata[7:0]  : 8'bzzzz_zzzz;

    assign dbg_state = state;

    // Memory array is not reset; only the committed bytes of a write are updated.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (!w_ub_n) begin
                mem[w_addr][15:8] <= w_data[15:8];
            end
            if (!w_lb_n) begin
                mem[w_addr][7:0] <= w_data[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            r_addr      <= '0;
            w_addr      <= '0;
            w_data      <= 16'h0000;
            w_ub_n      <= 1'b1;
            w_lb_n      <= 1'b1;
            cnt         <= 4'd0;
            wcnt        <= 4'd0;
            rdata       <= 16'h0000;
            readCount   <= 16'h0000;
            writeCount  <= 16'h0000;
            protocolErr <= 1'b0;
        end else begin
            if (both_low) begin
                protocolErr <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (wr) begin
                        w_addr <= idx;
                        w_data <= sramData;
                        w_ub_n <= ub_n;
                        w_lb_n <= lb_n;
                        wcnt   <= 4'd1;
                        state  <= WRITE_ACTIVE;
                    end else if (rd) begin
                        r_addr <= idx;
                        cnt    <= 4'd1;
                        if (LAT == 5'd1) begin
                            rdata     <= mem[idx];
                            readCount <= readCount + 16'd1;
                            state     <= READ_DRIVE;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end

                READ_WAIT: begin
                    if (!rd) begin
                        state <= IDLE;
                    end else if (idx != r_addr) begin
                        r_addr <= idx;
                        cnt    <= 4'd1;
                    end else if (cnt_inc == LAT) begin
                        cnt       <= cnt_inc[3:0];
                        rdata     <= mem[r_addr];
                        readCount <= readCount + 16'd1;
                        state     <= READ_DRIVE;
                    end else begin
                        cnt <= cnt_inc[3:0];
                    end
                end

                READ_DRIVE: begin
                    if (!rd) begin
                        state <= IDLE;
                    end else if (idx != r_addr) begin
                        // A new address restarts the latency count from one.
                        r_addr <= idx;
                        cnt    <= 4'd1;
                        if (LAT == 5'd1) begin
                            rdata     <= mem[idx];
                            readCount <= readCount + 16'd1;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end

                WRITE_ACTIVE: begin
                    if (wr) begin
                        w_data <= sramData;
                        w_ub_n <= ub_n;
                        w_lb_n <= lb_n;
                        if (wcnt != 4'd15) begin
                            wcnt <= wcnt + 4'd1;
                        end
                        if (idx != w_addr) begin
                            protocolErr <= 1'b1;
                            w_addr      <= idx;
                        end
                    end else begin
                        if (wcnt >= WMIN) begin
                            writeCount <= writeCount + 16'd1;
                        end else begin
                            protocolErr <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: memory model plus expected-data queue, pulled-up data
// bus so released lanes read as ones.
module tb_sram_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int READ_LAT   = 2;
    localparam int WR_MIN     = 3;
    localparam logic [4:0] CTRL_IDLE = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic [4:0]  ctrl;
    logic [15:0] tb_drive;
    logic        tb_oe;
    wire  [15:0] sram_data;
    logic [15:0] read_count;
    logic [15:0] write_count;
    logic        protocol_err;
    logic [1:0]  dbg_state;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [int];
    logic [15:0] exp_rcount = 16'd0;
    logic [15:0] exp_wcount = 16'd0;

    always #5 clk = ~clk;

    assign sram_data = tb_oe ? tb_drive : 16'hzzzz;

    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (sram_data[g]);
    end

    sram_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .READ_LAT  (READ_LAT),
        .WR_MIN    (WR_MIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sramAddress(addr),
        .sramData   (sram_data),
        .sramCtrl   (ctrl),
        .readCount  (read_count),
        .writeCount (write_count),
        .protocolErr(protocol_err),
        .dbg_state  (dbg_state)
    );

    function automatic int widx(input logic [17:0] a);
        return int'(a) & ((1 << DEPTH_LOG2) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; holds WR for 'cycles' rising edges, then releases.
    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input int cycles);
        logic [15:0] m;
        addr     = a;
        tb_drive = d;
        tb_oe    = 1'b1;
        ctrl     = {1'b0, 1'b1, ub, lb, 1'b0};
        repeat (cycles) @(negedge clk);
        ctrl  = CTRL_IDLE;
        tb_oe = 1'b0;
        @(negedge clk);
        if (cycles >= WR_MIN) begin
            m = model.exists(widx(a)) ? model[widx(a)] : 16'h0000;
            if (!ub) m[15:8] = d[15:8];
            if (!lb) m[7:0]  = d[7:0];
            model[widx(a)] = m;
            exp_wcount++;
        end
    endtask

    task automatic do_read(input logic [17:0] a, input logic ub, input logic lb, input string tag);
        logic [15:0] w;
        w = model.exists(widx(a)) ? model[widx(a)] : 16'h0000;
        exp_q.push_back({ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]});
        addr = a;
        ctrl = {1'b1, 1'b0, ub, lb, 1'b0};
        repeat (READ_LAT - 1) begin
            @(negedge clk);
            #1;
            check({tag, "_early"}, 32'(sram_data), 32'hFFFF);
        end
        @(negedge clk);
        #1;
        check(tag, 32'(sram_data), 32'(exp_q.pop_front()));
        exp_rcount++;
        ctrl = CTRL_IDLE;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        ctrl  = CTRL_IDLE;
        tb_oe = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        exp_rcount = 16'd0;
        exp_wcount = 16'd0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] ra;
        logic [15:0] rd_val;
        logic [15:0] rc_before;

        rst      = 1'b0;
        ctrl     = CTRL_IDLE;
        addr     = 18'h0;
        tb_drive = 16'h0;
        tb_oe    = 1'b0;
        #1;
        check("rst_rcount", 32'(read_count), 32'h0);
        check("rst_wcount", 32'(write_count), 32'h0);
        check("rst_err", 32'(protocol_err), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        check("rst_bus", 32'(sram_data), 32'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Write then read with exact latency.
        do_write(18'h00040, 16'hBEEF, 1'b0, 1'b0, WR_MIN);
        check("wr_count1", 32'(write_count), 32'(exp_wcount));
        do_read(18'h00040, 1'b0, 1'b0, "rd_beef");
        check("rd_count1", 32'(read_count), 32'(exp_rcount));

        // Reset while driving read data: bus releases at once, counters clear.
        do_write(18'h00010, 16'h0F0F, 1'b0, 1'b0, WR_MIN);
        addr = 18'h00010;
        ctrl = 5'b10000;
        @(negedge clk);
        #1;
        check("mid_read_wait_state", 32'(dbg_state), 32'h1);
        @(negedge clk);
        #1;
        check("mid_read_drive", 32'(sram_data), 32'h0F0F);
        rst = 1'b0;
        #1;
        check("mid_read_bus_rel", 32'(sram_data), 32'hFFFF);
        check("mid_read_rcount", 32'(read_count), 32'h0);
        check("mid_read_state_rst", 32'(dbg_state), 32'h0);
        ctrl = CTRL_IDLE;
        @(negedge clk);
        rst        = 1'b1;
        exp_rcount = 16'd0;
        exp_wcount = 16'd0;
        @(negedge clk);
        check("post_rst_state", 32'(dbg_state), 32'h0);

        // Byte lanes.
        do_write(18'h00005, 16'h1234, 1'b0, 1'b0, WR_MIN);
        do_write(18'h00005, 16'hABCD, 1'b1, 1'b0, WR_MIN);
        do_read(18'h00005, 1'b0, 1'b0, "lane_full");
        do_read(18'h00005, 1'b1, 1'b0, "lane_lo_only");
        do_read(18'h00005, 1'b0, 1'b1, "lane_hi_only");

        // Read restart on address change.
        do_write(18'h00007, 16'h7777, 1'b0, 1'b0, WR_MIN);
        do_write(18'h00008, 16'h8888, 1'b0, 1'b0, WR_MIN);
        rc_before = read_count;
        addr = 18'h00007;
        ctrl = 5'b10000;
        @(negedge clk);
        addr = 18'h00008;
        @(negedge clk);
        #1;
        check("restart_early", 32'(sram_data), 32'hFFFF);
        @(negedge clk);
        #1;
        check("restart_data", 32'(sram_data), 32'h8888);
        ctrl = CTRL_IDLE;
        @(negedge clk);
        check("restart_rcount", 32'(read_count), 32'(rc_before + 16'd1));
        exp_rcount = rc_before + 16'd1;

        // Simultaneous WE_N/OE_N/CE_N low with both lanes masked.
        check("err_clear", 32'(protocol_err), 32'h0);
        addr     = 18'h00005;
        tb_drive = 16'h0000;
        tb_oe    = 1'b1;
        ctrl     = 5'b00110;
        repeat (WR_MIN) @(negedge clk);
        ctrl  = CTRL_IDLE;
        tb_oe = 1'b0;
        @(negedge clk);
        exp_wcount++;
        check("both_low_err", 32'(protocol_err), 32'h1);
        check("masked_wcount", 32'(write_count), 32'(exp_wcount));
        do_read(18'h00005, 1'b0, 1'b0, "masked_nochange");
        check("err_sticky", 32'(protocol_err), 32'h1);

        // Short write pulse: flagged, no commit.
        pulse_reset();
        check("err_after_rst", 32'(protocol_err), 32'h0);
        do_write(18'h00040, 16'h0000, 1'b0, 1'b0, WR_MIN - 1);
        check("short_err", 32'(protocol_err), 32'h1);
        check("short_wcount", 32'(write_count), 32'(exp_wcount));
        do_read(18'h00040, 1'b0, 1'b0, "short_nocommit");

        // Address change during a write: flagged, last address wins.
        pulse_reset();
        addr     = 18'h00030;
        tb_drive = 16'h3131;
        tb_oe    = 1'b1;
        ctrl     = 5'b01000;
        @(negedge clk);
        addr = 18'h00031;
        repeat (WR_MIN - 1) @(negedge clk);
        ctrl  = CTRL_IDLE;
        tb_oe = 1'b0;
        @(negedge clk);
        model[widx(18'h00031)] = 16'h3131;
        exp_wcount++;
        check("addr_chg_err", 32'(protocol_err), 32'h1);
        check("addr_chg_wcount", 32'(write_count), 32'(exp_wcount));
        do_read(18'h00031, 1'b0, 1'b0, "addr_chg_data");

        // Aliasing modulo depth.
        do_write(18'h00400, 16'h5555, 1'b0, 1'b0, WR_MIN);
        do_read(18'h00000, 1'b0, 1'b0, "alias_read");

        // Random traffic against the model.
        for (int k = 0; k < 6; k++) begin
            ra     = 18'($urandom_range(0, 18'h3FFFF));
            rd_val = 16'($urandom_range(0, 16'hFFFF));
            do_write(ra, rd_val, 1'b0, 1'b0, WR_MIN + $urandom_range(0, 2));
            do_read(ra, 1'b0, 1'b0, "rand_read");
        end
        check("rand_wcount", 32'(write_count), 32'(exp_wcount));
        check("rand_rcount", 32'(read_count), 32'(exp_rcount));

        // Write counter wrap from all-ones.
        force dut.writeCount = 16'hFFFF;
        @(negedge clk);
        release dut.writeCount;
        @(negedge clk);
        do_write(18'h00002, 16'h2222, 1'b0, 1'b0, WR_MIN);
        check("wcount_wrap", 32'(write_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Clocked, synthesizable responder model of the 256K x 16 asynchronous SRAM chip on the board side of the sramData/sramAddress/sramCtrl bus.
- Answers the MEM-stage SRAM controller's read and write sequences with programmable read latency, byte-lane masking and a tri-state data bus.
- Flags protocol violations and counts completed transactions, so the controller and pipeline can be verified without board hardware.

Parameters:
- DEPTH_LOG2, 16, number of implemented words = 2^DEPTH_LOG2; address bits above this are ignored, so accesses alias modulo depth.
- READ_LAT, 2, cycles from read condition with stable address to data driven; legal range 1..15.
- WR_MIN, 1, minimum cycles WE_N must be low for a write to commit; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sramAddress  input  18  word address from controller.
- sramData  inout  16  bidirectional data bus; this block drives it only during reads.
- sramCtrl  input  5  {WE_N, OE_N, UB_N, LB_N, CE_N}: bit4 WE_N, bit3 OE_N, bit2 UB_N, bit1 LB_N, bit0 CE_N; all active-low.
- readCount  output  16  completed reads, wraps at 16'hFFFF -> 0.
- writeCount  output  16  committed writes, wraps at 16'hFFFF -> 0.
- protocolErr  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters=0, protocolErr=0, sramData released to Z immediately.
  - Any pending write is discarded. Memory contents are not cleared.
- Conditions, evaluated from sramCtrl each cycle:
  - RD = CE_N=0 & WE_N=1 & OE_N=0
  - WR = CE_N=0 & WE_N=0 (WE_N dominates OE_N)
- States: IDLE, READ_WAIT, READ_DRIVE, WRITE_ACTIVE.
- IDLE:
  - RD at posedge -> latch address, cnt=1, go READ_WAIT; if READ_LAT=1, go directly to READ_DRIVE instead.
  - WR at posedge -> capture address, data, UB_N, LB_N; wcnt=1; go WRITE_ACTIVE.
- READ_WAIT:
  - RD with address equal to latched address -> cnt++. When cnt reaches READ_LAT, load rdata=mem[addr], go READ_DRIVE, readCount++.
  - RD with a different address -> relatch the address, cnt=1, stay (restart).
  - Not RD -> IDLE, no count.
- READ_DRIVE:
  - sramData[15:8] = rdata[15:8] when RD & UB_N=0, else Z.
  - sramData[7:0] = rdata[7:0] when RD & LB_N=0, else Z.
  - Release is combinational on control deassert.
  - Address change while RD -> relatch, READ_WAIT, bus Z.
  - Not RD -> IDLE.
- WRITE_ACTIVE:
  - While WR: recapture data, UB_N, LB_N every cycle (last value wins); wcnt++ saturating at 15.
  - Address differing from captured address -> protocolErr=1; the new address is captured.
  - First posedge with not WR: if wcnt>=WR_MIN, write the enabled bytes of captured data to mem[addr] and writeCount++; otherwise protocolErr=1 and no commit. Go IDLE.
  - Ending with both UB_N=1 and LB_N=1 -> no memory change, writeCount still increments.
- protocolErr sets on any of:
  - CE_N=0 & WE_N=0 & OE_N=0 in the same cycle;
  - address change in WRITE_ACTIVE;
  - write pulse shorter than WR_MIN.
  - Cleared only by reset.
- Back-to-back accesses: leaving WRITE_ACTIVE into RD commits the write first; a read of the same address in the following READ_LAT cycles returns the new data.
- Never drives sramData while WE_N=0. Bus-hold or pull-ups are outside this block.

Test Plan:
- Reset mid-read: READ_LAT=2, assert RD at addr 0x00010, pulse rst low during READ_WAIT -> sramData Z immediately, readCount=0, state IDLE after release.
- Write then read: WR addr 0x00040 data 16'hBEEF for 2 cycles, release, then RD same addr -> sramData=16'hBEEF exactly 2 cycles after RD starts; writeCount=1, readCount=1.
- Byte lanes: mem[0x00005]=16'h1234; write 16'hABCD with UB_N=1, LB_N=0 -> read returns 16'h12CD. Reading with UB_N=1 -> sramData[15:8]=Z.
- Read restart: RD at 0x00007 for 1 cycle, then address 0x00008 -> data for 0x00008 appears READ_LAT cycles after the change; readCount increments once.
- Violations: WE_N=0, OE_N=0, CE_N=0 simultaneously -> protocolErr=1 and stays 1; with WR_MIN=3, a 2-cycle WE_N pulse -> no commit, writeCount unchanged.
- Aliasing and wrap: DEPTH_LOG2=10, write 16'h5555 at 0x00400 -> read at 0x00000 returns 16'h5555. Preloading writeCount to 16'hFFFF via 65535 writes, then one more write -> writeCount=0.
